// File: rtl/gpio_fab_reset_tick.sv
// Fabric reset sequencer: synchronizes init/request inputs, waits for a stable
// window before releasing FAB_RESET_N, and emits a periodic TICK while running.
module gpio_fab_reset_tick #(
    parameter int STABLE_CYCLES = 1024,
    parameter int TICK_DIV      = 50000
) (
    input  logic       CLK_BASE,
    input  logic       POWER_ON_RESET_N,
    input  logic       INIT_DONE,
    input  logic       FAB_RESET_REQ_N,
    output logic       FAB_RESET_N,
    output logic       READY,
    output logic       TICK,
    output logic [1:0] STATE
);
    localparam int STABLE_W = $clog2(STABLE_CYCLES);
    localparam int TICK_W   = $clog2(TICK_DIV);
    localparam logic [STABLE_W-1:0] STABLE_LAST = STABLE_W'(STABLE_CYCLES - 1);
    localparam logic [TICK_W-1:0]   TICK_LAST   = TICK_W'(TICK_DIV - 1);

    typedef enum logic [1:0] {
        RESET     = 2'd0,
        WAIT_INIT = 2'd1,
        STABLE    = 2'd2,
        RUN       = 2'd3
    } state_t;

    state_t              state;
    state_t              state_next;
    logic [STABLE_W-1:0] stable_cnt;
    logic [STABLE_W-1:0] stable_next;
    logic [TICK_W-1:0]   tick_cnt;
    logic                init_meta;
    logic                init_s;
    logic                req_meta;
    logic                req_s;
    logic                inputs_ok;

    // Two-flop synchronizers keep metastability on the raw inputs away from the FSM.
    always_ff @(posedge CLK_BASE or negedge POWER_ON_RESET_N) begin
        if (!POWER_ON_RESET_N) begin
            init_meta <= 1'b0;
            init_s    <= 1'b0;
            req_meta  <= 1'b0;
            req_s     <= 1'b0;
        end else begin
            init_meta <= INIT_DONE;
            init_s    <= init_meta;
            req_meta  <= FAB_RESET_REQ_N;
            req_s     <= req_meta;
        end
    end

    assign inputs_ok = init_s & req_s;

    always_comb begin
        state_next  = state;
        stable_next = stable_cnt;
        case (state)
            RESET: begin
                state_next  = WAIT_INIT;
                stable_next = '0;
            end
            WAIT_INIT: begin
                stable_next = '0;
                if (inputs_ok) begin
                    state_next = STABLE;
                end
            end
            STABLE: begin
                // A dropped input wins even on the terminal-count cycle.
                if (!inputs_ok) begin
                    state_next  = WAIT_INIT;
                    stable_next = '0;
                end else if (stable_cnt == STABLE_LAST) begin
                    state_next  = RUN;
                    stable_next = '0;
                end else begin
                    stable_next = stable_cnt + 1'b1;
                end
            end
            RUN: begin
                stable_next = '0;
                if (!inputs_ok) begin
                    state_next = WAIT_INIT;
                end
            end
            default: begin
                state_next  = RESET;
                stable_next = '0;
            end
        endcase
    end

    always_ff @(posedge CLK_BASE or negedge POWER_ON_RESET_N) begin
        if (!POWER_ON_RESET_N) begin
            state      <= RESET;
            stable_cnt <= '0;
        end else begin
            state      <= state_next;
            stable_cnt <= stable_next;
        end
    end

    // Outputs follow next-state so they move on the same edge as RUN entry/exit.
    always_ff @(posedge CLK_BASE or negedge POWER_ON_RESET_N) begin
        if (!POWER_ON_RESET_N) begin
            FAB_RESET_N <= 1'b0;
            READY       <= 1'b0;
            TICK        <= 1'b0;
            tick_cnt    <= '0;
        end else begin
            FAB_RESET_N <= (state_next == RUN);
            READY       <= (state_next == RUN);
            if (state == RUN && state_next == RUN) begin
                if (tick_cnt == TICK_LAST) begin
                    tick_cnt <= '0;
                    TICK     <= 1'b1;
                end else begin
                    tick_cnt <= tick_cnt + 1'b1;
                    TICK     <= 1'b0;
                end
            end else begin
                tick_cnt <= '0;
                TICK     <= 1'b0;
            end
        end
    end

    assign STATE = state;

endmodule
